pad_sensor_link: RTL and testbench

Physical-side counterpart of the VGA game controller's pad interface. Synchronizes and debounces the 15 raw active-low drum-pad sensor lines, stretches each hit so the pixel-rate consumer cannot miss it, and packs them into the 32-bit active-low sensor word the controller reads. In the other direction it decodes the controller's 32-bit active-low pad-select word into pad LED drives, blanking a pad's LED once that pad has been struck.

---
 rtl/pad_sensor_link_if.sv | 42 ++++
 rtl/pad_sensor_link.sv | 195 +++++++++++++++++++
 tb/tb_pad_sensor_link.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_sensor_link_if.sv
// ---------------------------------------------------------------------------
// pad_sensor_link_if
//   Signal bundle between the drum-pad hardware/controller side and the
//   pad_sensor_link block.
//
//   raw_sensor  [14:0]  raw active-low sensor lines (pad1=[14:10], pad2=[9:5],
//                       pad3=[4:0], MSB of each group is the center sensor)
//   game_cmd    [31:0]  active-low one-hot pad-select word from the controller
//   sensor_word [31:0]  active-low packed sensor word back to the controller
//   pad_led     [2:0]   LED drive, 1 = lit, bit0 = pad1
//   hit_strobe  [2:0]   one-cycle pulse on the first accepted contact of a pad
//   center_hit  [2:0]   pulses with hit_strobe when the center sensor was hit
//
//   master: drives raw_sensor/game_cmd (board + controller side)
//   slave : the pad_sensor_link block
// ---------------------------------------------------------------------------
interface pad_sensor_link_if;
  logic [14:0] raw_sensor;
  logic [31:0] game_cmd;
  logic [31:0] sensor_word;
  logic [2:0]  pad_led;
  logic [2:0]  hit_strobe;
  logic [2:0]  center_hit;

  modport master (
    output raw_sensor,
    output game_cmd,
    input  sensor_word,
    input  pad_led,
    input  hit_strobe,
    input  center_hit
  );

  modport slave (
    input  raw_sensor,
    input  game_cmd,
    output sensor_word,
    output pad_led,
    output hit_strobe,
    output center_hit
  );
endinterface

// File: rtl/pad_sensor_link.sv
// ---------------------------------------------------------------------------
// pad_sensor_link
//   Physical-side partner of the VGA game controller's pad interface.
//   - Synchronizes and debounces the 15 raw active-low sensor lines.
//   - Per pad, captures the first contact, pulses hit_strobe/center_hit and
//     stretches the captured pattern on sensor_word for HOLD_CYCLES cycles,
//     accumulating further contacts while held.
//   - Decodes the controller's pad-select word into LED drives and blanks a
//     selected pad's LED once that pad has been struck.
//
// Ports:
//   iVGA_CLK  pixel clock, all logic on the rising edge
//   iRST_n    asynchronous active-low reset
//   link      pad_sensor_link_if.slave (raw_sensor, game_cmd in;
//             sensor_word, pad_led, hit_strobe, center_hit out)
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a raw level must be stable to be accepted (>= 2)
//   HOLD_CYCLES      minimum cycles a captured hit stays on sensor_word (>= 2)
// ---------------------------------------------------------------------------
module pad_sensor_link #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 2500000
) (
  input  logic            iVGA_CLK,
  input  logic            iRST_n,
  pad_sensor_link_if.slave link
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    REARM = 2'd2
  } pad_state_e;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer, idle level (no contact) is 1.
  // -------------------------------------------------------------------------
  logic [14:0] sync1, sync2;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      // NOTE: non-blocking assignments make sync2 take last cycle's sync1,
      // giving two real flop stages; blocking here would collapse them.
      sync1 <= link.raw_sensor;
      sync2 <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-bit debounce: the counter only runs while the synced level disagrees
  // with the accepted level; any agreement restarts it.
  // -------------------------------------------------------------------------
  logic [14:0]      deb;
  logic [DEB_W-1:0] deb_cnt [15];

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      deb <= '1;
      // NOTE: deb_cnt is a bank of individual counters, not a RAM, so every
      // entry is reset along with the rest of the state.
      for (int i = 0; i < 15; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-pad capture FSM. Pad p (0 = pad1) owns deb[14-5p -: 5].
  // -------------------------------------------------------------------------
  logic [14:0] pad_bits;
  logic [2:0]  strobe_bits;
  logic [2:0]  center_bits;

  for (genvar p = 0; p < 3; p++) begin : g_pad
    pad_state_e        state_q, state_d;
    logic [4:0]        grp, cap_q, cap_d, out_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              strobe, center;

    assign grp = deb[14-5*p -: 5];

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
        state_q <= IDLE;
        cap_q   <= '1;
        hold_q  <= '0;
      end else begin
        state_q <= state_d;
        cap_q   <= cap_d;
        hold_q  <= hold_d;
      end
    end

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d = state_q;
      cap_d   = cap_q;
      hold_d  = hold_q;
      out_d   = grp;
      strobe  = 1'b0;
      center  = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grp != 5'b11111) begin
            cap_d   = grp;
            hold_d  = '0;
            strobe  = 1'b1;
            center  = ~grp[4];
            state_d = HELD;
          end
        end
        HELD: begin
          // Late contacts are merged into the held pattern; releases are not.
          cap_d = cap_q & grp;
          out_d = cap_q & grp;
          if (hold_q == HOLD_LAST) state_d = REARM;
          else                     hold_d  = hold_q + 1'b1;
        end
        REARM: begin
          // Wait for a full release so one long press yields one strobe.
          if (grp == 5'b11111) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    assign pad_bits[14-5*p -: 5] = out_d;
    assign strobe_bits[p]        = strobe;
    assign center_bits[p]        = center;
  end

  // -------------------------------------------------------------------------
  // Command decode and LED acknowledge.
  // -------------------------------------------------------------------------
  logic [31:0] cmd_q;
  logic [31:0] sensor_word_q;
  logic [2:0]  hit_strobe_q, center_hit_q, pad_led_q;
  logic [2:0]  ack, ack_d, sel_new;
  logic        cmd_valid, changed;

  always_comb begin
    cmd_valid = (&link.game_cmd[31:3]) &&
                (link.game_cmd[2:0] == 3'b110 ||
                 link.game_cmd[2:0] == 3'b101 ||
                 link.game_cmd[2:0] == 3'b011);
    sel_new   = cmd_valid ? ~link.game_cmd[2:0] : 3'b000;
    changed   = (link.game_cmd != cmd_q);
    // A new command clears old acks, but a strobe landing on the same cycle
    // still acknowledges the newly selected pad.
    ack_d     = (changed ? 3'b000 : ack) | (hit_strobe_q & sel_new);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cmd_q         <= '1;
      ack           <= '0;
      pad_led_q     <= '0;
      sensor_word_q <= '1;
      hit_strobe_q  <= '0;
      center_hit_q  <= '0;
    end else begin
      cmd_q         <= link.game_cmd;
      ack           <= ack_d;
      pad_led_q     <= sel_new & ~ack_d;
      sensor_word_q <= {17'h1FFFF, pad_bits};
      hit_strobe_q  <= strobe_bits;
      center_hit_q  <= center_bits;
    end
  end

  assign link.sensor_word = sensor_word_q;
  assign link.pad_led     = pad_led_q;
  assign link.hit_strobe  = hit_strobe_q;
  assign link.center_hit  = center_hit_q;

endmodule

// File: tb/tb_pad_sensor_link.sv
// ---------------------------------------------------------------------------
// tb_pad_sensor_link
//   Bench for pad_sensor_link with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
//   Expected hits are queued when the contact is driven (cycle, strobe,
//   center, sensor_word) and a negedge monitor pops them as strobes appear.
//   Scenario tasks add their own level checks on sensor_word and pad_led.
// ---------------------------------------------------------------------------
module tb_pad_sensor_link;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int LAT  = DEB + 3;   // raw edge to output

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;

  typedef struct {
    int          cyc;
    logic [2:0]  strobe;
    logic [2:0]  center;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  pad_sensor_link_if bus ();

  pad_sensor_link #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .iVGA_CLK(clk),
    .iRST_n  (rst_n),
    .link    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every strobe must match the oldest queued hit.
  always @(negedge clk) begin
    if (bus.hit_strobe !== 3'b000) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: cycle %0d strobe %b, no hit expected", cyc, bus.hit_strobe);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.cyc || bus.hit_strobe !== mon_e.strobe ||
            bus.center_hit !== mon_e.center || bus.sensor_word !== mon_e.word) begin
          n_err++;
          $display("FAIL scoreboard_hit: got cyc %0d strobe %b center %b word %h, expected cyc %0d strobe %b center %b word %h",
                   cyc, bus.hit_strobe, bus.center_hit, bus.sensor_word,
                   mon_e.cyc, mon_e.strobe, mon_e.center, mon_e.word);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue a hit whose contact is being driven on the current cycle.
  task automatic expect_hit(input logic [2:0] s, input logic [2:0] c, input logic [31:0] w);
    exp_t e;
    e.cyc    = cyc + LAT;
    e.strobe = s;
    e.center = c;
    e.word   = w;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL reset_word: got %h, expected ffffffff", bus.sensor_word);
    end
    n_vec++;
    if (bus.pad_led !== 3'b000) begin
      n_err++; $display("FAIL reset_led: got %b, expected 000", bus.pad_led);
    end
    n_vec++;
    if (bus.hit_strobe !== 3'b000 || bus.center_hit !== 3'b000) begin
      n_err++; $display("FAIL reset_strobe: got %b/%b, expected 000/000", bus.hit_strobe, bus.center_hit);
    end
    rst_n = 1'b1;
    repeat (10) tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFFF || bus.pad_led !== 3'b000) begin
      n_err++; $display("FAIL reset_release: got word %h led %b, expected ffffffff 000", bus.sensor_word, bus.pad_led);
    end
  endtask

  task automatic test_debounce();
    // Glitch one cycle shorter than the debounce window.
    bus.raw_sensor[14] = 1'b0;
    repeat (DEB - 1) tick();
    bus.raw_sensor[14] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (bus.sensor_word !== 32'hFFFFFFFF) begin
        n_err++; $display("FAIL glitch_word: got %h, expected ffffffff", bus.sensor_word);
      end
    end
    // Real contact on the pad1 center sensor.
    bus.raw_sensor[14] = 1'b0;
    expect_hit(3'b001, 3'b001, 32'hFFFFBFFF);
    repeat (LAT - 1) tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFFF || bus.hit_strobe !== 3'b000) begin
      n_err++; $display("FAIL debounce_early: got word %h strobe %b, expected ffffffff 000", bus.sensor_word, bus.hit_strobe);
    end
    tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFBFFF || bus.hit_strobe !== 3'b001 || bus.center_hit !== 3'b001) begin
      n_err++; $display("FAIL debounce_hit: got word %h strobe %b center %b, expected ffffbfff 001 001",
                        bus.sensor_word, bus.hit_strobe, bus.center_hit);
    end
    tick();
    n_vec++;
    if (bus.hit_strobe !== 3'b000 || bus.center_hit !== 3'b000) begin
      n_err++; $display("FAIL strobe_width: got %b/%b, expected 000/000", bus.hit_strobe, bus.center_hit);
    end
    bus.raw_sensor[14] = 1'b1;
    repeat (25) tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL debounce_release: got %h, expected ffffffff", bus.sensor_word);
    end
  endtask

  task automatic test_stretch();
    bus.raw_sensor[5] = 1'b0;
    expect_hit(3'b010, 3'b000, 32'hFFFFFFDF);
    repeat (5) tick();
    bus.raw_sensor[5] = 1'b1;                 // released long before the hold ends
    repeat (2) tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFDF || bus.hit_strobe !== 3'b010) begin
      n_err++; $display("FAIL stretch_hit: got word %h strobe %b, expected ffffffdf 010", bus.sensor_word, bus.hit_strobe);
    end
    bus.raw_sensor[6] = 1'b0;                 // second contact while held
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      n_vec++;
      if (bus.sensor_word[5] !== 1'b0) begin
        n_err++; $display("FAIL stretch_hold: got bit5 %b at step %0d, expected 0", bus.sensor_word[5], i);
      end
    end
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFF9F) begin
      n_err++; $display("FAIL accumulate: got %h, expected ffffff9f", bus.sensor_word);
    end
    repeat (2) tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFBF) begin
      n_err++; $display("FAIL rearm_passthrough: got %h, expected ffffffbf", bus.sensor_word);
    end
    // New contact while not fully released must not strobe.
    bus.raw_sensor[5] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_vec++;
      if (bus.hit_strobe !== 3'b000) begin
        n_err++; $display("FAIL rearm_no_strobe: got %b, expected 000", bus.hit_strobe);
      end
    end
    bus.raw_sensor[6:5] = 2'b11;
    repeat (10) tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL rearm_release: got %h, expected ffffffff", bus.sensor_word);
    end
    bus.raw_sensor[5] = 1'b0;
    expect_hit(3'b010, 3'b000, 32'hFFFFFFDF);
    repeat (LAT) tick();
    n_vec++;
    if (bus.hit_strobe !== 3'b010) begin
      n_err++; $display("FAIL restrobe: got %b, expected 010", bus.hit_strobe);
    end
    bus.raw_sensor[5] = 1'b1;
    repeat (25) tick();
  endtask

  task automatic test_simultaneous();
    bus.raw_sensor[0]  = 1'b0;
    bus.raw_sensor[10] = 1'b0;
    expect_hit(3'b101, 3'b000, 32'hFFFFFBFE);
    repeat (LAT) tick();
    n_vec++;
    if (bus.hit_strobe !== 3'b101 || bus.sensor_word !== 32'hFFFFFBFE) begin
      n_err++; $display("FAIL simultaneous: got strobe %b word %h, expected 101 fffffbfe", bus.hit_strobe, bus.sensor_word);
    end
    tick();
    n_vec++;
    if (bus.hit_strobe !== 3'b000) begin
      n_err++; $display("FAIL simultaneous_width: got %b, expected 000", bus.hit_strobe);
    end
    bus.raw_sensor[0]  = 1'b1;
    bus.raw_sensor[10] = 1'b1;
    repeat (25) tick();
  endtask

  task automatic test_led_ack();
    bus.game_cmd = 32'hFFFFFFFD;
    tick();
    n_vec++;
    if (bus.pad_led !== 3'b010) begin
      n_err++; $display("FAIL led_select: got %b, expected 010", bus.pad_led);
    end
    // Hit on an unselected pad leaves the LED alone.
    bus.raw_sensor[0] = 1'b0;
    expect_hit(3'b100, 3'b000, 32'hFFFFFFFE);
    repeat (LAT) tick();
    bus.raw_sensor[0] = 1'b1;
    tick();
    n_vec++;
    if (bus.pad_led !== 3'b010) begin
      n_err++; $display("FAIL led_other_pad: got %b, expected 010", bus.pad_led);
    end
    repeat (25) tick();
    // Hit on the selected pad blanks its LED one cycle after the strobe.
    bus.raw_sensor[5] = 1'b0;
    expect_hit(3'b010, 3'b000, 32'hFFFFFFDF);
    repeat (LAT) tick();
    n_vec++;
    if (bus.pad_led !== 3'b010) begin
      n_err++; $display("FAIL led_at_strobe: got %b, expected 010", bus.pad_led);
    end
    tick();
    n_vec++;
    if (bus.pad_led !== 3'b000) begin
      n_err++; $display("FAIL led_ack: got %b, expected 000", bus.pad_led);
    end
    bus.raw_sensor[5] = 1'b1;
    repeat (25) tick();
    n_vec++;
    if (bus.pad_led !== 3'b000) begin
      n_err++; $display("FAIL led_ack_persist: got %b, expected 000", bus.pad_led);
    end
    bus.game_cmd = 32'hFFFFFFFB;
    tick();
    n_vec++;
    if (bus.pad_led !== 3'b100) begin
      n_err++; $display("FAIL led_pad3: got %b, expected 100", bus.pad_led);
    end
    bus.game_cmd = 32'hFFFFFFFC;
    tick();
    n_vec++;
    if (bus.pad_led !== 3'b000) begin
      n_err++; $display("FAIL led_invalid: got %b, expected 000", bus.pad_led);
    end
    bus.game_cmd = 32'hFFFFFFFF;
    tick();
  endtask

  task automatic test_collision();
    bus.game_cmd = 32'hFFFFFFFE;
    tick();
    n_vec++;
    if (bus.pad_led !== 3'b001) begin
      n_err++; $display("FAIL collision_pre: got %b, expected 001", bus.pad_led);
    end
    bus.raw_sensor[5] = 1'b0;
    expect_hit(3'b010, 3'b000, 32'hFFFFFFDF);
    repeat (LAT) tick();
    n_vec++;
    if (bus.hit_strobe !== 3'b010) begin
      n_err++; $display("FAIL collision_strobe: got %b, expected 010", bus.hit_strobe);
    end
    bus.game_cmd = 32'hFFFFFFFD;              // changes during the strobe cycle
    tick();
    n_vec++;
    if (bus.pad_led !== 3'b000) begin
      n_err++; $display("FAIL collision_led: got %b, expected 000", bus.pad_led);
    end
    repeat (3) tick();
    n_vec++;
    if (bus.pad_led !== 3'b000) begin
      n_err++; $display("FAIL collision_persist: got %b, expected 000", bus.pad_led);
    end
    bus.raw_sensor[5] = 1'b1;
    repeat (25) tick();
    bus.game_cmd = 32'hFFFFFFFF;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.game_cmd = 32'hFFFFFFFD;
    tick();
    bus.raw_sensor[4] = 1'b0;                 // pad3 center, pad3 not selected
    expect_hit(3'b100, 3'b100, 32'hFFFFFFEF);
    repeat (LAT + 2) tick();
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFEF || bus.pad_led !== 3'b010) begin
      n_err++; $display("FAIL mid_held: got word %h led %b, expected ffffffef 010", bus.sensor_word, bus.pad_led);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.sensor_word !== 32'hFFFFFFFF || bus.pad_led !== 3'b000 || bus.hit_strobe !== 3'b000) begin
      n_err++; $display("FAIL mid_reset: got word %h led %b strobe %b, expected ffffffff 000 000",
                        bus.sensor_word, bus.pad_led, bus.hit_strobe);
    end
    bus.raw_sensor = '1;
    bus.game_cmd   = '1;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_vec++;
      if (bus.sensor_word !== 32'hFFFFFFFF || bus.pad_led !== 3'b000 || bus.hit_strobe !== 3'b000) begin
        n_err++; $display("FAIL mid_release: got word %h led %b strobe %b, expected ffffffff 000 000",
                          bus.sensor_word, bus.pad_led, bus.hit_strobe);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.raw_sensor = '1;
    bus.game_cmd   = '1;
    test_reset();
    test_debounce();
    test_stretch();
    test_simultaneous();
    test_led_ack();
    test_collision();
    test_reset_mid();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d hits still pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
